collapse_bank_mc: RTL

Multi-channel, parametrised successor to the ENP-P collapse bank. It holds N one-shot cells (value, basis, occupancy, lifetime) in internal registers and serves NCH independent read channels through round-robin arbitration into a single valid/ready response stage. Every read destroys the addressed cell:

- a basis match returns the stored value;
- a basis mismatch or an empty cell returns entropy and grounds the cell.

---
 rtl/collapse_bank_mc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/collapse_bank_mc.sv
// collapse_bank_mc: bank of N one-shot cells read through NCH round-robin channels.
// Every granted read destroys its cell: a basis match returns the stored value, a
// mismatch or an empty cell returns entropy. Cells may carry a lifetime (ttl) after
// which they clear themselves and bump a saturating expiry counter.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   init_*                     cell load request (always accepted out of reset)
//   rd_valid/rd_ready          per-channel read request / grant (combinational)
//   rd_addr/rd_basis           packed per-channel address and basis
//   rsp_*                      registered single-entry response stage
//   entropy_i/entropy_valid_i  TRNG word; reads are only granted when valid
//   occupied_vec, mismatch_ground_vec, expire_cnt  status outputs
module collapse_bank_mc #(
  parameter int unsigned N       = 64,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned BASIS_W = 8,
  parameter int unsigned NCH     = 2,
  parameter int unsigned TTL_W   = 16,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_valid,
  output logic                   init_ready,
  input  logic [ADDR_W-1:0]      init_addr,
  input  logic [DATA_W-1:0]      init_value,
  input  logic [BASIS_W-1:0]     init_basis,
  input  logic [TTL_W-1:0]       init_ttl,
  input  logic [NCH-1:0]         rd_valid,
  output logic [NCH-1:0]         rd_ready,
  input  logic [NCH*ADDR_W-1:0]  rd_addr,
  input  logic [NCH*BASIS_W-1:0] rd_basis,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CH_W-1:0]        rsp_ch,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [1:0]             rsp_status,
  input  logic [DATA_W-1:0]      entropy_i,
  input  logic                   entropy_valid_i,
  output logic [N-1:0]           occupied_vec,
  output logic [N-1:0]           mismatch_ground_vec,
  output logic [15:0]            expire_cnt
);

  localparam logic [1:0] StatMatch    = 2'd0;
  localparam logic [1:0] StatMismatch = 2'd1;
  localparam logic [1:0] StatEmpty    = 2'd2;
  localparam int unsigned CntW = ADDR_W + 1;

  logic [DATA_W-1:0]  value_q [N];
  logic [DATA_W-1:0]  value_d [N];
  logic [BASIS_W-1:0] basis_q [N];
  logic [BASIS_W-1:0] basis_d [N];
  logic [TTL_W-1:0]   ttl_q   [N];
  logic [TTL_W-1:0]   ttl_d   [N];
  logic [N-1:0]       occ_q, occ_d;
  logic [N-1:0]       mg_q, mg_d;
  logic [15:0]        expire_cnt_q, expire_cnt_d;
  logic [CH_W-1:0]    last_grant_q, last_grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]    rsp_ch_q, rsp_ch_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]         rsp_status_q, rsp_status_d;

  logic               init_fire;
  logic               rsp_free;
  logic [NCH-1:0]     eligible;
  logic               grant_vld;
  logic [CH_W-1:0]    grant_ch;
  logic [ADDR_W-1:0]  g_addr;
  logic [BASIS_W-1:0] g_basis;
  logic [CntW-1:0]    n_exp;
  logic [16:0]        exp_sum;

  assign init_ready = rst_n;
  assign init_fire  = init_valid & rst_n;
  assign rsp_free   = ~rsp_valid_q | rsp_ready;

  // A read colliding with a same-cycle init to its cell is held off so init wins cleanly.
  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      eligible[c] = rst_n & rd_valid[c] & entropy_valid_i & rsp_free &
                    ~(init_fire && (init_addr == rd_addr[c*ADDR_W +: ADDR_W]));
    end
  end

  // Round-robin: first eligible channel above last_grant, else wrap to the lowest.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (!grant_vld && eligible[c] && (c > int'(last_grant_q))) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
    for (int c = 0; c < int'(NCH); c++) begin
      if (!grant_vld && eligible[c] && (c <= int'(last_grant_q))) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
  end

  always_comb begin
    g_addr  = '0;
    g_basis = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      rd_ready[c] = grant_vld && (grant_ch == CH_W'(c));
      if (grant_ch == CH_W'(c)) begin
        g_addr  = rd_addr[c*ADDR_W +: ADDR_W];
        g_basis = rd_basis[c*BASIS_W +: BASIS_W];
      end
    end
  end

  // Per-cell next state; priority init > read collapse > ttl countdown.
  always_comb begin
    value_d = value_q;
    basis_d = basis_q;
    ttl_d   = ttl_q;
    occ_d   = occ_q;
    mg_d    = mg_q;
    n_exp   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (init_fire && (init_addr == ADDR_W'(i))) begin
        value_d[i] = init_value;
        basis_d[i] = init_basis;
        ttl_d[i]   = init_ttl;
        occ_d[i]   = 1'b1;
        mg_d[i]    = 1'b0;
      end else if (grant_vld && (g_addr == ADDR_W'(i))) begin
        value_d[i] = '0;
        basis_d[i] = '0;
        ttl_d[i]   = '0;
        occ_d[i]   = 1'b0;
        if (occ_q[i] && (basis_q[i] != g_basis)) mg_d[i] = 1'b1;
      end else if (occ_q[i] && (ttl_q[i] != '0)) begin
        if (ttl_q[i] == TTL_W'(1)) begin
          value_d[i] = '0;
          basis_d[i] = '0;
          ttl_d[i]   = '0;
          occ_d[i]   = 1'b0;
          n_exp      = n_exp + CntW'(1);
        end else begin
          ttl_d[i] = ttl_q[i] - TTL_W'(1);
        end
      end
    end
    exp_sum      = {1'b0, expire_cnt_q} + 17'(n_exp);
    expire_cnt_d = exp_sum[16] ? 16'hFFFF : exp_sum[15:0];
  end

  // Response stage; outcome uses pre-edge cell contents.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_ch_d     = rsp_ch_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      rsp_valid_d  = 1'b1;
      rsp_ch_d     = grant_ch;
      last_grant_d = grant_ch;
      if (!occ_q[g_addr]) begin
        rsp_status_d = StatEmpty;
        rsp_data_d   = entropy_i;
      end else if (basis_q[g_addr] == g_basis) begin
        rsp_status_d = StatMatch;
        rsp_data_d   = value_q[g_addr];
      end else begin
        rsp_status_d = StatMismatch;
        rsp_data_d   = entropy_i;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        value_q[i] <= '0;
        basis_q[i] <= '0;
        ttl_q[i]   <= '0;
      end
      occ_q        <= '0;
      mg_q         <= '0;
      expire_cnt_q <= '0;
      last_grant_q <= CH_W'(NCH - 1);
      rsp_valid_q  <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      value_q      <= value_d;
      basis_q      <= basis_d;
      ttl_q        <= ttl_d;
      occ_q        <= occ_d;
      mg_q         <= mg_d;
      expire_cnt_q <= expire_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ch_q     <= rsp_ch_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign rsp_valid           = rsp_valid_q;
  assign rsp_ch              = rsp_ch_q;
  assign rsp_data            = rsp_data_q;
  assign rsp_status          = rsp_status_q;
  assign occupied_vec        = occ_q;
  assign mismatch_ground_vec = mg_q;
  assign expire_cnt          = expire_cnt_q;

endmodule
